spi_txn_arbiter: RTL
====================

// Module: spi_txn_arbiter
// PURPOSE
//  Shares one SPI master (fsm_spi-class, 1-byte transfers) between NREQ requesters.
//  Picks requesters round-robin, captures each one's TX byte and launches the master.
//  Returns the RX byte and a completion pulse to the requester that was served.
//  Sits between client logic and the SPI master; mosi/cs/sclk stay inside the master.
// PARAMETERS
//  NREQ     4     number of requesters (>=2)
//  DW       8     SPI word width
//  TIMEOUT  1023  max cycles in WAIT before a transfer is aborted (>=1)
// PORTS
//  clk          in   1        system clock, all logic on posedge
//  rst          in   1        synchronous, active-high reset
//  req          in   NREQ     request; level, held until own gnt bit seen
//  req_data     in   NREQ*DW  TX bytes, requester i at [i*DW +: DW]
//  gnt          out  NREQ     one-hot, 1-cycle pulse: request accepted, data captured
//  done         out  NREQ     one-hot, 1-cycle pulse: transfer of that requester ended
//  rdata        out  DW       RX byte, valid while done!=0
//  err          out  1        1-cycle pulse with done when transfer timed out
//  spi_start    out  1        1-cycle launch pulse to SPI master
//  spi_txdata   out  DW       byte to master, stable from spi_start until done
//  spi_busy     in   1        master busy (start ignored while high)
//  spi_done     in   1        master 1-cycle completion pulse
//  spi_rxdata   in   DW       master RX byte, valid with spi_done
// BEHAVIOUR
//  - Reset: state IDLE; gnt, done, rdata, err, spi_start, spi_txdata all 0;
//    last=NREQ-1 (requester 0 wins first); timeout counter 0. All outputs registered.
//  - FSM IDLE -> LAUNCH -> WAIT -> IDLE.
//  - IDLE: if |req, sel = first set bit scanning last+1, last+2, ... mod NREQ.
//    Next cycle: gnt[sel]=1, spi_txdata<=req_data[sel], state LAUNCH. No req: stay.
//  - LAUNCH: wait while spi_busy=1; when spi_busy=0, spi_start=1 for one cycle,
//    counter cleared, -> WAIT. Minimum req->spi_start latency 2 cycles.
//  - WAIT: counter++ each cycle. spi_done=1 -> rdata<=spi_rxdata, done[sel]=1,
//    err=0, last<=sel, -> IDLE. Counter==TIMEOUT and no spi_done -> done[sel]=1,
//    err=1, rdata=0, last<=sel, -> IDLE.
//  - spi_done and timeout in same cycle: spi_done wins, err=0.
//  - spi_done outside WAIT ignored (no done, no state change).
//  - req changes outside IDLE ignored; requester must drop req after gnt or it is
//    re-served in its next round-robin turn. Never two gnt bits set.
//  - Earliest re-arbitration: cycle after done (IDLE re-entered); no back-to-back
//    gnt without an intervening done.
//  - Counter width $clog2(TIMEOUT+1); no wrap possible (exits at TIMEOUT).
//  - rst mid-transfer: next cycle returns to reset values; no done/err emitted for the
//    aborted transfer; master is reset by the same rst.
// TESTING
//  1 rst high 5 cycles, req=4'hF -> all outputs 0 throughout; after release gnt=4'b0001 first.
//  2 req=4'b0010, data1=8'hA5; model spi_done after 16 cycles, rx=8'h3C -> gnt=0010 once,
//    spi_start once with spi_txdata=A5, then done=0010, rdata=3C, err=0.
//  3 req=4'hF held continuously -> grant order 0,1,2,3,0,1; one done per grant.
//  4 spi_busy held high 20 cycles after gnt -> spi_start asserts only on first cycle busy=0.
//  5 TIMEOUT=15, model never pulses spi_done -> done[sel]=1, err=1, rdata=0 at 16th WAIT cycle.
//  6 rst pulsed during WAIT of requester 2 -> no done/err; next req=4'hF grants requester 0.

Source files
------------

// File: rtl/spi_txn_arbiter.sv
// spi_txn_arbiter: round-robin arbiter that shares one byte-wide SPI master
// between NREQ requesters. Each winner's TX byte is captured, the master is
// launched, and the RX byte (or a timeout error) goes back to that requester.
module spi_txn_arbiter #(
    parameter int NREQ    = 4,
    parameter int DW      = 8,
    parameter int TIMEOUT = 1023
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    done,
    output logic [DW-1:0]      rdata,
    output logic               err,
    output logic               spi_start,
    output logic [DW-1:0]      spi_txdata,
    input  logic               spi_busy,
    input  logic               spi_done,
    input  logic [DW-1:0]      spi_rxdata
);

    localparam int          IW       = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int          CW       = $clog2(TIMEOUT + 1);
    localparam int unsigned NR       = NREQ;
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
    localparam logic [IW-1:0] LAST_RST = IW'(NREQ - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   last_q, last_d;
    logic [IW-1:0]   sel_q, sel_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] done_q, done_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic [DW-1:0]   txd_q, txd_d;
    logic            err_q, err_d;
    logic            start_q, start_d;

    logic            found;
    logic [IW-1:0]   pick;
    int unsigned     rr_idx;

    // Round-robin pick: first requester set, scanning upward from last winner + 1
    always_comb begin
        found  = 1'b0;
        pick   = last_q;
        rr_idx = 0;
        for (int unsigned i = 1; i <= NR; i++) begin
            rr_idx = (int'(last_q) + i) % NR;
            if (!found && req[rr_idx[IW-1:0]]) begin
                found = 1'b1;
                pick  = rr_idx[IW-1:0];
            end
        end
    end

    // Next-state and registered-output logic for the IDLE/LAUNCH/WAIT sequence
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        txd_d   = txd_q;
        gnt_d   = '0;
        done_d  = '0;
        rdata_d = '0;
        err_d   = 1'b0;
        start_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (found) begin
                    sel_d       = pick;
                    gnt_d[pick] = 1'b1;
                    txd_d       = req_data[int'(pick)*DW +: DW];
                    state_d     = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                if (!spi_busy) begin
                    start_d = 1'b1;
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // A completion in the same cycle as the timeout takes priority
                if (spi_done) begin
                    rdata_d        = spi_rxdata;
                    done_d[sel_q]  = 1'b1;
                    last_d         = sel_q;
                    state_d        = S_IDLE;
                end else if (cnt_q == CNT_MAX) begin
                    done_d[sel_q]  = 1'b1;
                    err_d          = 1'b1;
                    last_d         = sel_q;
                    state_d        = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            last_q  <= LAST_RST;
            sel_q   <= '0;
            cnt_q   <= '0;
            txd_q   <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            txd_q   <= txd_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            start_q <= start_d;
        end
    end

    assign gnt        = gnt_q;
    assign done       = done_q;
    assign rdata      = rdata_q;
    assign err        = err_q;
    assign spi_start  = start_q;
    assign spi_txdata = txd_q;

endmodule
